// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared definitions for the reset release sequencer.
//   state_e    - FSM state encoding (SYNC, DELAY, WAIT_ACK, DONE, FAULT)
//   clog2      - ceiling log2 for sizing counters and indices
//   clog2_min1 - clog2 clamped to at least one bit, for vector widths
package rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_SYNC     = 3'd0,
        ST_DELAY    = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_DONE     = 3'd3,
        ST_FAULT    = 3'd4
    } state_e;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    function automatic int clog2_min1(input int value);
        return (clog2(value) < 1) ? 1 : clog2(value);
    endfunction

endpackage

// File: rtl/rst_seq_sync.sv
// rst_seq_sync: W-bit two-flop synchronizer with asynchronous clear.
//   clk_i - destination clock
//   clr_i - asynchronous active-high clear; both flop stages go to zero
//   d_i   - asynchronous input bits
//   q_o   - synchronized output, two clk_i edges after d_i is sampled
module rst_seq_sync #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/rst_seq.sv
// rst_seq: multi-stage reset release sequencer.
// Holds NUM_STAGES downstream resets asserted, then releases them one at a
// time in index order, waiting for each stage's acknowledge before the next.
// A lost acknowledge or an acknowledge timeout latches a fault that
// re-asserts every stage until async_rst is asserted again.
//   clk         - single clock, rising edge
//   async_rst   - asynchronous active-high reset, release synchronized inside
//   stage_ack   - per-stage ready/locked, asynchronous, synchronized inside
//   stage_rst   - per-stage active-high reset, bit 0 released first
//   seq_done    - all stages released and acknowledged
//   seq_fault   - latched fault flag
//   fault_stage - index of the stage that caused the fault
//   dbg_state_o - current FSM state
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int NUM_STAGES  = 4,
    parameter int STAGE_DELAY = 16,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic                                  clk,
    input  logic                                  async_rst,
    input  logic [NUM_STAGES-1:0]                 stage_ack,
    output logic [NUM_STAGES-1:0]                 stage_rst,
    output logic                                  seq_done,
    output logic                                  seq_fault,
    output logic [clog2_min1(NUM_STAGES)-1:0]     fault_stage,
    output state_e                                dbg_state_o
);

    localparam int KW = clog2_min1(NUM_STAGES);
    localparam int DW = clog2_min1(STAGE_DELAY + 1);
    localparam int TW = clog2_min1(ACK_TIMEOUT + 1);

    // Counters start at zero on the edge that enters their state, so the
    // terminal event happens when the count reaches its limit minus one.
    localparam logic [DW-1:0] DLY_LAST = DW'(STAGE_DELAY - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);
    localparam logic [KW-1:0] K_LAST   = KW'(NUM_STAGES - 1);

    state_e                  state_q, state_d;
    logic [KW-1:0]           k_q, k_d;
    logic [DW-1:0]           dcnt_q, dcnt_d;
    logic [TW-1:0]           tcnt_q, tcnt_d;
    logic [NUM_STAGES-1:0]   stage_rst_q, stage_rst_d;
    logic [KW-1:0]           fault_stage_q, fault_stage_d;

    logic                    rst_rel;
    logic [NUM_STAGES-1:0]   ack_s;
    logic                    lost;
    logic [KW-1:0]           lost_idx;

    // Constant-one input: the synchronized copy rises two edges after
    // async_rst falls and clears immediately when it rises.
    rst_seq_sync #(.W(1)) u_rst_sync (
        .clk_i (clk),
        .clr_i (async_rst),
        .d_i   (1'b1),
        .q_o   (rst_rel)
    );

    rst_seq_sync #(.W(NUM_STAGES)) u_ack_sync (
        .clk_i (clk),
        .clr_i (async_rst),
        .d_i   (stage_ack),
        .q_o   (ack_s)
    );

    // Ack-loss detection: stages below k while sequencing, every stage once
    // done. Scanning from the top down leaves the lowest dropped index.
    always_comb begin
        lost     = 1'b0;
        lost_idx = '0;
        for (int j = NUM_STAGES - 1; j >= 0; j--) begin
            if (!ack_s[j] &&
                ((state_q == ST_DONE) ||
                 (((state_q == ST_DELAY) || (state_q == ST_WAIT_ACK)) && (j < int'(k_q))))) begin
                lost     = 1'b1;
                lost_idx = KW'(j);
            end
        end
    end

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            state_q       <= ST_SYNC;
            k_q           <= '0;
            dcnt_q        <= '0;
            tcnt_q        <= '0;
            stage_rst_q   <= '1;
            fault_stage_q <= '0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            dcnt_q        <= dcnt_d;
            tcnt_q        <= tcnt_d;
            stage_rst_q   <= stage_rst_d;
            fault_stage_q <= fault_stage_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        dcnt_d        = dcnt_q;
        tcnt_d        = tcnt_q;
        stage_rst_d   = stage_rst_q;
        fault_stage_d = fault_stage_q;

        case (state_q)
            ST_SYNC: begin
                if (rst_rel) begin
                    state_d = ST_DELAY;
                    dcnt_d  = '0;
                end
            end

            ST_DELAY: begin
                // Ack loss takes priority over the release.
                if (lost) begin
                    state_d       = ST_FAULT;
                    stage_rst_d   = '1;
                    fault_stage_d = lost_idx;
                end else if (dcnt_q == DLY_LAST) begin
                    stage_rst_d[k_q] = 1'b0;
                    state_d          = ST_WAIT_ACK;
                    tcnt_d           = '0;
                end else if (dcnt_q != '1) begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end

            ST_WAIT_ACK: begin
                // Priority: earlier-stage loss, then ack, then timeout, so an
                // ack arriving on the final allowed edge is still accepted.
                if (lost) begin
                    state_d       = ST_FAULT;
                    stage_rst_d   = '1;
                    fault_stage_d = lost_idx;
                end else if (ack_s[k_q]) begin
                    if (k_q == K_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        k_d     = k_q + 1'b1;
                        dcnt_d  = '0;
                        state_d = ST_DELAY;
                    end
                end else if ((ACK_TIMEOUT != 0) && (tcnt_q == TMO_LAST)) begin
                    state_d       = ST_FAULT;
                    stage_rst_d   = '1;
                    fault_stage_d = k_q;
                end else if (tcnt_q != '1) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end

            ST_DONE: begin
                if (lost) begin
                    state_d       = ST_FAULT;
                    stage_rst_d   = '1;
                    fault_stage_d = lost_idx;
                end
            end

            ST_FAULT: begin
                // Held until async_rst; no automatic retry.
            end

            default: begin
                state_d = ST_SYNC;
            end
        endcase
    end

    assign stage_rst   = stage_rst_q;
    assign seq_done    = (state_q == ST_DONE);
    assign seq_fault   = (state_q == ST_FAULT);
    assign fault_stage = fault_stage_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/rst_seq.md
# rst_seq

Multi-stage reset release sequencer. It sits downstream of the power-on reset generator. It takes the asynchronous, active-high system reset and holds up to NUM_STAGES downstream reset outputs asserted. It then releases them one at a time, in index order, and waits for a ready/locked acknowledge from each stage before releasing the next. Missing or lost acknowledges are reported as a latched fault.

## Interface
- NUM_STAGES, 4: number of sequenced reset outputs (1..16).
- STAGE_DELAY, 16: cycles between a qualifying event and the next reset release (≥1).
- ACK_TIMEOUT, 1024: cycles allowed for a stage acknowledge after its release; 0 disables timeout.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- async_rst  in  1  asynchronous, active-high reset; assertion acts immediately, release is synchronized internally.
- stage_ack  in  NUM_STAGES  per-stage ready/locked; asynchronous to clk; 2-flop synchronized internally.
- stage_rst  out  NUM_STAGES  per-stage reset, active-high; bit 0 is released first.
- seq_done  out  1  all stages released and acknowledged.
- seq_fault  out  1  latched fault flag.
- fault_stage  out  clog2(NUM_STAGES) (min 1)  stage index that caused the fault.

## Operation
- Reset values while async_rst is high: stage_rst all ones, seq_done 0, seq_fault 0, fault_stage 0, FSM in SYNC, stage index k=0, synchronizers cleared.
- FSM states and transitions:
  - SYNC: wait for the synchronized reset release, then go to DELAY.
  - DELAY: count STAGE_DELAY cycles, then deassert stage_rst[k] and go to WAIT_ACK.
  - WAIT_ACK: on synchronized ack[k] high, go to DONE if k is the last stage, else increment k and go to DELAY.
  - DONE: hold.
  - FAULT: hold.
- Released stages stay released (stage_rst bit stays 0) except on fault.
- Ack-loss monitoring:
  - In DELAY, WAIT_ACK and DONE, any already-acknowledged stage j<k whose synced ack drops goes to FAULT with fault_stage=j.
  - In DONE this applies to all stages.
  - If several stages drop together, the lowest index is reported.
- Timeout: in WAIT_ACK, no ack[k] within ACK_TIMEOUT cycles goes to FAULT with fault_stage=k.
- FAULT actions:
  - stage_rst is driven to all ones, re-asserting every stage.
  - seq_fault=1 and seq_done=0.
  - The state is held until async_rst is asserted; there is no automatic retry.
- Counters: delay counter is clog2(STAGE_DELAY+1) bits; timeout counter is clog2(ACK_TIMEOUT+1) bits; both saturate and never wrap.

## Timing
- Edge 0 is the first rising edge sampling async_rst low.
- Release synchronizer: two flops, so the internal release is seen after edge 1 and DELAY is entered at edge 2.
- First release R0 = edge 2+STAGE_DELAY; stage_rst[0] is low after that edge.
- Ack sampling: ack[k] is sampled at edges R_k+1 onward, synced copy only; a raw ack change takes 2 edges to become visible.
- Next release: with A_k the first edge where synced ack[k] is high, R_{k+1} = A_k+STAGE_DELAY.
- Completion: seq_done is high after edge A_last.
- Timeout window: ack is accepted at edges R_k+1..R_k+ACK_TIMEOUT. If ack is still low at R_k+ACK_TIMEOUT, FAULT is entered at that edge.
- Simultaneous events:
  - Ack and timeout on the same edge: ack wins.
  - Earlier-stage ack loss together with any other event: fault wins.
- Reset mid-operation: all outputs return to reset values asynchronously, and the sequence restarts from R0 timing after release.

## Structure
- Package rst_seq_pkg holds:
  - the FSM state encoding localparams (SYNC, DELAY, WAIT_ACK, DONE, FAULT);
  - the clog2 function.
- Sub-module rst_seq_sync is a parameterized-width 2-flop synchronizer with asynchronous clear. It is instantiated twice:
  - width 1 for reset release;
  - width NUM_STAGES for stage_ack.

## Test plan
All scenarios use NUM_STAGES=3, STAGE_DELAY=4, ACK_TIMEOUT=16.
- Nominal, acks tied high: stage_rst falls in order 0/1/2 at edges 6/11/16; seq_done rises at edge 17; seq_fault stays 0.
- Late ack: ack[1] raised at edge 20. Stage 1 is released at 11, the synced ack is seen at 22, and stage_rst[2] falls at 26.
- Timeout: ack[2] never raised. FAULT at edge 32, stage_rst=3'b111, seq_fault=1, fault_stage=2.
- Boundary ack: synced ack[2] first high exactly at R2+16. It is accepted, with no fault, and seq_done rises.
- Ack loss after done: drop ack[0] and ack[1] together. seq_fault=1, fault_stage=0, all resets re-asserted; then pulse async_rst and the nominal sequence repeats with identical edge numbers.
- async_rst pulsed during DELAY of stage 1: stage_rst immediately returns to 3'b111, seq_done=0, and the restart timing matches the nominal case.
